// File: rtl/factorial_inverse.sv
// -----------------------------------------------------------------------------
// factorial_inverse
//
// Sequential inverse of a factorial encoder. For an OUT_W-bit operand it finds
// the largest n in [1, 2^N-1] with n! <= value, and reports that n together
// with a flag telling whether n! matches the operand exactly. A zero operand
// has no such n and is flagged as invalid without entering the search.
//
// The search walks upward from 1! and performs one multiply per clock, so the
// latency equals the result n (plus the accept edge).
//
// Parameters
//   N      width of the result; the result saturates at 2^N-1
//   OUT_W  width of the operand
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset; aborts any search in progress
//   start    request pulse, sampled only while idle
//   value    operand, captured on the edge that accepts start
//   busy     high while a search is running
//   done     one-cycle pulse when number/exact/invalid carry a fresh result
//   number   largest n with n! <= value
//   exact    high when number! == value
//   invalid  high when the operand was zero
// -----------------------------------------------------------------------------
module factorial_inverse #(
   parameter int N     = 4,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OUT_W-1:0] value,
   output logic             busy,
   output logic             done,
   output logic [N-1:0]     number,
   output logic             exact,
   output logic             invalid
);

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   localparam logic [N-1:0]     N_MAX   = {N{1'b1}};
   localparam logic [N-1:0]     N_ONE   = N'(1);
   localparam logic [OUT_W-1:0] VAL_ONE = OUT_W'(1);

   // Registered state and its next-state counterparts
   state_t           state, state_next;
   logic [OUT_W-1:0] val_r, val_next;
   logic [OUT_W-1:0] prod, prod_next;
   logic [N-1:0]     n_r, n_next;
   logic [N-1:0]     number_next;
   logic             done_next;
   logic             exact_next;
   logic             invalid_next;

   // Datapath: next candidate factorial (n_r+1)! = prod * (n_r+1).
   // The multiplier operand is one bit wider than n_r so that n_r+1 cannot
   // wrap, and the product is kept at OUT_W+N bits, which holds any
   // OUT_W-bit value times a factor of at most 2^N without truncation.
   logic [N:0]         mult;
   logic [OUT_W+N-1:0] cand;
   logic               stop;

   always_comb begin
      mult = {1'b0, n_r} + {{N{1'b0}}, 1'b1};
      cand = {{N{1'b0}}, prod} * {{(OUT_W-1){1'b0}}, mult};
      // Stop either at the largest representable n or when the next
      // factorial would exceed the operand.
      stop = (n_r == N_MAX) || (cand > {{N{1'b0}}, val_r});
   end

   // State register and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         val_r   <= '0;
         prod    <= '0;
         n_r     <= '0;
         number  <= '0;
         done    <= 1'b0;
         exact   <= 1'b0;
         invalid <= 1'b0;
      end else begin
         state   <= state_next;
         val_r   <= val_next;
         prod    <= prod_next;
         n_r     <= n_next;
         number  <= number_next;
         done    <= done_next;
         exact   <= exact_next;
         invalid <= invalid_next;
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_next   = state;
      val_next     = val_r;
      prod_next    = prod;
      n_next       = n_r;
      number_next  = number;
      exact_next   = exact;
      invalid_next = invalid;
      done_next    = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               if (value == '0) begin
                  // No n satisfies n! <= 0: answer immediately.
                  number_next  = '0;
                  exact_next   = 1'b0;
                  invalid_next = 1'b1;
                  done_next    = 1'b1;
               end else begin
                  // Seed the search with 1! = 1; any nonzero operand
                  // satisfies it, so the result is at least 1.
                  val_next     = value;
                  prod_next    = VAL_ONE;
                  n_next       = N_ONE;
                  invalid_next = 1'b0;
                  state_next   = CALC;
               end
            end
         end

         CALC: begin
            if (stop) begin
               number_next = n_r;
               exact_next  = (prod == val_r);
               done_next   = 1'b1;
               state_next  = IDLE;
            end else begin
               // cand <= val_r here, so the upper N bits are zero.
               prod_next = cand[OUT_W-1:0];
               n_next    = n_r + N_ONE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy = (state == CALC);

endmodule
